dfr_output_capture: RTL and testbench

//  Downstream stage of the DFR core. Captures each 26-bit reservoir result into an internal

---
 rtl/dfr_output_capture.sv | 119 +++++++++++
 tb/tb_dfr_output_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dfr_output_capture.sv
// dfr_output_capture: captures DFR results into a sample buffer with a registered host read port.
// Optional dropped-write counter built only when DFR_OUT_DROP_CNT_EN is defined.
module dfr_output_capture #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 26,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic              dfr_output_ram_wen,
    input  logic [DATA_W-1:0] dfr_output,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   wr_count,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              capturing,
    output logic              full,
    output logic [15:0]       drop_count
);
    localparam int DEPTH_N = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FULL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, wr_addr;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic                full_q, full_d, capturing_q, capturing_d, rd_valid_q, rd_valid_d, we;
    logic [31:0]         rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   mem [DEPTH_N];

    // Next state: stop beats arm; arm re-bases pointers so a coincident strobe lands at address 0
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        we         = 1'b0;
        wr_addr    = wr_ptr_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            if (arm) begin
                state_d    = S_CAPTURE;
                wr_ptr_d   = '0;
                wr_count_d = '0;
            end
            if (dfr_output_ram_wen && (arm || state_q == S_CAPTURE)) begin
                we       = 1'b1;
                wr_addr  = wr_ptr_d;
                wr_ptr_d = wr_ptr_d + 1'b1;
                wr_count_d = (wr_count_d == DEPTH) ? wr_count_d : wr_count_d + 1'b1;
                if (wr_count_d == DEPTH && WRAP == 0) state_d = S_FULL;
            end
        end
        full_d      = (wr_count_d == DEPTH);
        capturing_d = (state_d == S_CAPTURE);
        rd_valid_d  = rd_en;
        rd_data_d   = rd_en ? {{(32-DATA_W){mem[rd_addr][DATA_W-1]}}, mem[rd_addr]} : rd_data_q;
    end

    // Control and read-port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wr_count_q  <= '0;
            full_q      <= 1'b0;
            capturing_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_count_q  <= wr_count_d;
            full_q      <= full_d;
            capturing_q <= capturing_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Sample buffer write port, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= dfr_output;
    end

`ifdef DFR_OUT_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    // Saturating count of strobes refused while the buffer is full
    always_comb begin
        drop_count_d = drop_count_q;
        if (!stop && arm) drop_count_d = '0;
        else if (!stop && state_q == S_FULL && dfr_output_ram_wen && drop_count_q != 16'hFFFF)
            drop_count_d = drop_count_q + 1'b1;
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (reset) drop_count_q <= '0;
        else drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 16'h0000;
`endif

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_count  = wr_count_q;
    assign wr_ptr    = wr_ptr_q;
    assign capturing = capturing_q;
    assign full      = full_q;
endmodule

// File: tb/tb_dfr_output_capture.sv
// tb_dfr_output_capture: scoreboard bench driving a WRAP=0 and a WRAP=1 instance with shared stimulus.
module tb_dfr_output_capture;
    localparam int AW = 3;
    localparam int DW = 26;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1, arm = 1'b0, stop = 1'b0, wen = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] raddr = '0;
    logic [31:0] rd_data [2];
    logic        rd_valid [2];
    logic [AW:0] wr_count [2];
    logic [AW-1:0] wr_ptr [2];
    logic        capturing [2];
    logic        full [2];
    logic [15:0] drop_count [2];

    dfr_output_capture #(.ADDR_W(AW), .DATA_W(DW), .WRAP(0)) u0 (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .dfr_output_ram_wen(wen),
        .dfr_output(din), .rd_en(rd_en), .rd_addr(raddr), .rd_data(rd_data[0]),
        .rd_valid(rd_valid[0]), .wr_count(wr_count[0]), .wr_ptr(wr_ptr[0]),
        .capturing(capturing[0]), .full(full[0]), .drop_count(drop_count[0]));

    dfr_output_capture #(.ADDR_W(AW), .DATA_W(DW), .WRAP(1)) u1 (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .dfr_output_ram_wen(wen),
        .dfr_output(din), .rd_en(rd_en), .rd_addr(raddr), .rd_data(rd_data[1]),
        .rd_valid(rd_valid[1]), .wr_count(wr_count[1]), .wr_ptr(wr_ptr[1]),
        .capturing(capturing[1]), .full(full[1]), .drop_count(drop_count[1]));

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int ptr;
        bit cap;
        bit full;
        bit rv;
        int drop;
    } st_t;

    st_t sq0[$], sq1[$];
    logic [31:0] rq0[$], rq1[$];
    int mmem [2][N];
    int mcnt [2], mptr [2], mst [2], mdrop [2];
    int checks = 0, fails = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, d, act, exp);
        end
    endtask

    function automatic logic [31:0] sext(input int v);
        return {{6{v[25]}}, v[25:0]};
    endfunction

    // Reference model: mode 0 idle, 1 capturing, 2 full; the buffer is an array of ints
    task automatic update(input int d);
        st_t e;
        if (reset) begin
            mst[d] = 0; mcnt[d] = 0; mptr[d] = 0; mdrop[d] = 0;
            e.rv = 1'b0;
        end else begin
            if (rd_en) begin
                if (d == 0) rq0.push_back(sext(mmem[d][raddr]));
                else rq1.push_back(sext(mmem[d][raddr]));
            end
            if (stop) mst[d] = 0;
            else begin
                if (arm) begin
                    mst[d] = 1; mcnt[d] = 0; mptr[d] = 0; mdrop[d] = 0;
                end
                if (wen && mst[d] == 1) begin
                    mmem[d][mptr[d]] = int'(din);
                    mptr[d] = (mptr[d] + 1) % N;
                    if (mcnt[d] < N) mcnt[d]++;
                    if (mcnt[d] == N && d == 0) mst[d] = 2;
                end else if (wen && mst[d] == 2) begin
`ifdef DFR_OUT_DROP_CNT_EN
                    if (mdrop[d] < 65535) mdrop[d]++;
`endif
                end
            end
            e.rv = rd_en;
        end
        e.cnt = mcnt[d]; e.ptr = mptr[d]; e.cap = (mst[d] == 1); e.full = (mcnt[d] == N); e.drop = mdrop[d];
        if (d == 0) sq0.push_back(e);
        else sq1.push_back(e);
    endtask

    task automatic check_dut(input int d, input st_t e);
        logic [31:0] exp_rd;
        chk("wr_count", d, 32'(wr_count[d]), e.cnt);
        chk("wr_ptr", d, 32'(wr_ptr[d]), e.ptr);
        chk("capturing", d, 32'(capturing[d]), 32'(e.cap));
        chk("full", d, 32'(full[d]), 32'(e.full));
        chk("drop_count", d, 32'(drop_count[d]), e.drop);
        chk("rd_valid", d, 32'(rd_valid[d]), 32'(e.rv));
        if (rd_valid[d] === 1'b1) begin
            if ((d == 0 ? rq0.size() : rq1.size()) == 0) begin
                chk("rd_unexpected", d, 32'd1, 32'd0);
            end else begin
                exp_rd = (d == 0) ? rq0.pop_front() : rq1.pop_front();
                chk("rd_data", d, rd_data[d], exp_rd);
            end
        end
    endtask

    // Monitor: compares both instances against the oldest expectation each cycle
    always @(negedge clk) begin
        if (sq0.size() > 0) check_dut(0, sq0.pop_front());
        if (sq1.size() > 0) check_dut(1, sq1.pop_front());
    end

    task automatic step(input bit rs, input bit a, input bit s, input bit w, input logic [DW-1:0] dv,
                        input bit re, input logic [AW-1:0] ra);
        reset = rs; arm = a; stop = s; wen = w; din = dv; rd_en = re; raddr = ra;
        @(posedge clk);
        update(0);
        update(1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, '0);
    endtask

    initial begin
        #1;
        step(1, 0, 0, 0, '0, 0, '0);
        step(1, 0, 0, 0, '0, 0, '0);
        chk("reset_rd_data", 0, rd_data[0], 32'h0);
        // idle writes are ignored
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 26'(i + 1), 0, '0);
        chk("idle_count", 0, 32'(wr_count[0]), 32'd0);
        chk("idle_cap", 1, 32'(capturing[1]), 32'd0);
        // sign extension of three captured samples
        step(0, 1, 0, 0, '0, 0, '0);
        step(0, 0, 0, 1, 26'h0000005, 0, '0);
        step(0, 0, 0, 1, 26'h3FFFFFF, 0, '0);
        step(0, 0, 0, 1, 26'h2000000, 0, '0);
        step(0, 0, 0, 0, '0, 1, 3'd0);
        chk("t2_rd0", 0, rd_data[0], 32'h00000005);
        step(0, 0, 0, 0, '0, 1, 3'd1);
        chk("t2_rd1", 0, rd_data[0], 32'hFFFFFFFF);
        step(0, 0, 0, 0, '0, 1, 3'd2);
        chk("t2_rd2", 1, rd_data[1], 32'hFE000000);
        step(0, 0, 0, 0, '0, 0, '0);
        chk("t2_valid_drop", 0, 32'(rd_valid[0]), 32'd0);
        // overfill: stop-at-full vs circular overwrite
        step(0, 1, 0, 0, '0, 0, '0);
        for (int i = 1; i <= 10; i++) step(0, 0, 0, 1, 26'(i), 0, '0);
        chk("t3_full", 0, 32'(full[0]), 32'd1);
        chk("t3_count", 0, 32'(wr_count[0]), 32'd8);
        chk("t3_cap", 0, 32'(capturing[0]), 32'd0);
`ifdef DFR_OUT_DROP_CNT_EN
        chk("t3_drop", 0, 32'(drop_count[0]), 32'd2);
`else
        chk("t3_drop", 0, 32'(drop_count[0]), 32'd0);
`endif
        chk("t4_count", 1, 32'(wr_count[1]), 32'd8);
        chk("t4_ptr", 1, 32'(wr_ptr[1]), 32'd2);
        chk("t4_full", 1, 32'(full[1]), 32'd1);
        chk("t4_cap", 1, 32'(capturing[1]), 32'd1);
        step(0, 0, 0, 0, '0, 1, 3'd0);
        chk("t4_rd0", 1, rd_data[1], 32'd9);
        chk("t3_rd0", 0, rd_data[0], 32'd1);
        step(0, 0, 0, 0, '0, 1, 3'd1);
        chk("t4_rd1", 1, rd_data[1], 32'd10);
        step(0, 0, 0, 0, '0, 1, 3'd2);
        chk("t4_rd2", 1, rd_data[1], 32'd3);
        // arm and stop together, stop mid-capture, reset mid-capture
        step(0, 1, 1, 0, '0, 0, '0);
        chk("t5_armstop", 1, 32'(capturing[1]), 32'd0);
        step(0, 1, 0, 0, '0, 0, '0);
        step(0, 0, 0, 1, 26'h11, 0, '0);
        step(0, 0, 0, 1, 26'h22, 0, '0);
        step(0, 0, 1, 0, '0, 0, '0);
        step(0, 0, 0, 1, 26'h33, 0, '0);
        chk("t5_stopcount", 0, 32'(wr_count[0]), 32'd2);
        step(0, 1, 0, 1, 26'h44, 1, 3'd1);
        step(1, 0, 0, 1, 26'h55, 1, 3'd1);
        chk("t5_rst_rd_data", 0, rd_data[0], 32'h0);
        chk("t5_rst_count", 1, 32'(wr_count[1]), 32'd0);
        // read-before-write on address 0
        step(0, 1, 0, 1, 26'd7, 0, '0);
        step(0, 1, 0, 1, 26'd9, 1, 3'd0);
        chk("t6_old", 0, rd_data[0], 32'd7);
        step(0, 0, 0, 0, '0, 1, 3'd0);
        chk("t6_new", 1, rd_data[1], 32'd9);
        // randomized traffic
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 2) == 0, AW'($urandom));
        idle(2);
        @(negedge clk);
        #1;
        chk("rdq0_empty", 0, rq0.size(), 32'd0);
        chk("rdq1_empty", 1, rq1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
